ofifo_drain_arbiter: RTL

- Round-robin drain scheduler for a bank of `col` depth-64 output FIFOs, one per array column.
- Shares a single registered write channel toward the psum SRAM among all FIFOs.
- Issues one-hot `fifo_rd` pulses only to non-empty FIFOs and captures the selected FIFO word.
- Generates sequential SRAM write addresses for a programmed burst; sits between the OFIFO bank and the SRAM/SFU write port in the core.

---
 rtl/ofifo_drain_arbiter_if.sv | 35 +++
 rtl/ofifo_drain_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ofifo_drain_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// ofifo_drain_arbiter_if : OFIFO bank read side plus SRAM write channel bundle
// Revision 1.0
// =============================================================================
interface ofifo_drain_arbiter_if #(
  parameter int COL    = 8,
  parameter int BW     = 16,
  parameter int ADDR_W = 11
);
  localparam int CW = (COL > 1) ? $clog2(COL) : 1;

  logic [COL-1:0]    fifo_empty;
  logic [COL-1:0]    fifo_full;
  logic [COL*BW-1:0] fifo_out;
  logic [COL-1:0]    fifo_rd;
  logic [BW-1:0]     dout;
  logic              dout_valid;
  logic              dout_ready;
  logic [CW-1:0]     dout_col;
  logic [ADDR_W-1:0] waddr;

  modport master (
    input  fifo_empty, fifo_full, fifo_out, dout_ready,
    output fifo_rd, dout, dout_valid, dout_col, waddr
  );

  modport slave (
    output fifo_empty, fifo_full, fifo_out, dout_ready,
    input  fifo_rd, dout, dout_valid, dout_col, waddr
  );
endinterface

`default_nettype wire

// File: rtl/ofifo_drain_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// ofifo_drain_arbiter : round-robin OFIFO drain onto one registered SRAM write
// channel; optional sticky overflow flags under macro OFIFO_OVF_FLAG_EN.
// Revision 1.0
// =============================================================================
module ofifo_drain_arbiter #(
  parameter int COL    = 8,
  parameter int BW     = 16,
  parameter int ADDR_W = 11
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 en,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W-1:0]    num_words,
  ofifo_drain_arbiter_if.master bus,
  output logic                 busy,
  output logic                 done
`ifdef OFIFO_OVF_FLAG_EN
  ,
  output logic                 ovf_err,
  output logic [COL-1:0]       ovf_col
`endif
);
  localparam int CW = (COL > 1) ? $clog2(COL) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [CW-1:0]     rr_ptr;
  logic [CW-1:0]     gnt;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] num_q;
  logic [ADDR_W-1:0] issued;
  logic [BW-1:0]     gnt_word;
  logic              any_ready;
  logic              slot_free;
  logic              issue;
  logic              last_issue;

  function automatic logic [CW-1:0] rr_index(input logic [CW-1:0] base, input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= COL) s = s - COL;
    return CW'(s);
  endfunction

  // Scan from the far end so the lowest offset from rr_ptr wins.
  always_comb begin
    gnt       = rr_ptr;
    any_ready = 1'b0;
    for (int k = COL - 1; k >= 0; k--) begin
      if (!bus.fifo_empty[rr_index(rr_ptr, k)]) begin
        gnt       = rr_index(rr_ptr, k);
        any_ready = 1'b1;
      end
    end
  end

  assign slot_free  = !bus.dout_valid || bus.dout_ready;
  assign last_issue = (issued + ADDR_W'(1)) == num_q;
  assign issue      = reset_n && (state == S_RUN) && en && slot_free &&
                      (issued < num_q) && any_ready;

  always_comb begin
    gnt_word    = '0;
    bus.fifo_rd = '0;
    for (int i = 0; i < COL; i++) begin
      if (gnt == CW'(i)) begin
        gnt_word       = bus.fifo_out[i*BW +: BW];
        bus.fifo_rd[i] = issue;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      rr_ptr         <= '0;
      base_q         <= '0;
      num_q          <= '0;
      issued         <= '0;
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
      bus.dout_col   <= '0;
      bus.waddr      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      if (issue) begin
        bus.dout       <= gnt_word;
        bus.dout_col   <= gnt;
        bus.waddr      <= base_q + issued;
        bus.dout_valid <= 1'b1;
        issued         <= issued + ADDR_W'(1);
        rr_ptr         <= (gnt == CW'(COL - 1)) ? '0 : gnt + 1'b1;
      end else if (bus.dout_valid && bus.dout_ready) begin
        bus.dout_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            base_q <= base_addr;
            num_q  <= num_words;
            issued <= '0;
            if (num_words == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
              busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (issue && last_issue) state <= S_FLUSH;
        end
        // The final word leaves on the same edge that moves us to DONE.
        S_FLUSH: begin
          if (slot_free) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef OFIFO_OVF_FLAG_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovf_col <= '0;
    end else if ((state == S_IDLE) && start) begin
      ovf_col <= '0;
    end else if (busy) begin
      ovf_col <= ovf_col | bus.fifo_full;
    end
  end

  assign ovf_err = |ovf_col;
`else
  logic unused_fifo_full;
  assign unused_fifo_full = ^bus.fifo_full;
`endif

endmodule

`default_nettype wire
